// File: rtl/branch_flush_ctrl.sv
// branch_flush_ctrl: EX-stage redirect/flush, load-use stall and halt control; BRANCH_STATS_EN adds saturating counters.
module branch_flush_ctrl #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_sel,
  input  logic [31:0]      br_pc,
  input  logic             halt,
  input  logic             hazard_stall,
  input  logic             resume,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] target_q, target_d;
  logic halted_q;
  logic take, stall_ev;
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    redirect_pc = target_q;
    pc_write    = 1'b0;
    pc_redirect = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    take        = 1'b0;
    stall_ev    = 1'b0;
    if (reset) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (halt) begin
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            state_d    = HALT;
          end else if (pc_sel) begin
            pc_write    = 1'b1;
            pc_redirect = 1'b1;
            redirect_pc = br_pc[PC_W-1:0];
            target_d    = br_pc[PC_W-1:0];
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            take        = 1'b1;
            state_d     = FLUSH;
          end else if (hazard_stall) begin
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
            stall_ev   = 1'b1;
          end else begin
            pc_write = 1'b1;
          end
        end
        FLUSH: begin
          pc_write = 1'b1;
          state_d  = RUN;
        end
        HALT: begin
          stall_ifid = 1'b1;
          flush_idex = 1'b1;
          state_d    = resume ? RUN : HALT;
        end
        default: state_d = RUN;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      target_q <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      halted_q <= state_d == HALT;
    end
  end
  assign halted = halted_q & ~reset;
`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_q, taken_d, stall_q, stall_d;
  logic unused_br;
  assign unused_br = ^br_pc[31:PC_W];
  assign taken_d = taken_q + CNT_W'(take && !(&taken_q));
  assign stall_d = stall_q + CNT_W'(stall_ev && !(&stall_q));
  always_ff @(posedge clk) begin
    if (reset) begin
      taken_q <= '0;
      stall_q <= '0;
    end else begin
      taken_q <= taken_d;
      stall_q <= stall_d;
    end
  end
  assign taken_cnt = taken_q;
  assign stall_cnt = stall_q;
`else
  logic unused_br;
  assign unused_br = ^{br_pc[31:PC_W], take, stall_ev};
  assign taken_cnt = '0;
  assign stall_cnt = '0;
`endif
endmodule

// File: doc/branch_flush_ctrl.md
BRANCH_FLUSH_CTRL -- requirements
Module: branch_flush_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 9, width of the program counter the block redirects.
REQ-002 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port pc_sel  in  1  EX-stage redirect request (branch taken, jump or halt).
REQ-006 SHALL have port br_pc  in  32  EX-stage redirect target.
REQ-007 SHALL have port halt  in  1  EX-stage halt instruction indicator.
REQ-008 SHALL have port hazard_stall  in  1  ID-stage load-use stall request.
REQ-009 SHALL have port resume  in  1  external request to leave the halted state.
REQ-010 SHALL have port pc_write  out  1  PC register write enable.
REQ-011 SHALL have port pc_redirect  out  1  PC mux select; 1 = take redirect_pc, 0 = PC+4.
REQ-012 SHALL have port redirect_pc  out  PC_W  redirect target.
REQ-013 SHALL have port stall_ifid  out  1  hold the IF/ID register.
REQ-014 SHALL have port flush_ifid  out  1  clear IF/ID to a bubble.
REQ-015 SHALL have port flush_idex  out  1  clear ID/EX to a bubble.
REQ-016 SHALL have port halted  out  1  high while in HALT.
REQ-017 SHALL have ports taken_cnt and stall_cnt  out  CNT_W  redirect and stall counts.

Function
REQ-018 SHALL implement a three-state FSM: RUN, FLUSH, HALT.
REQ-019 SHALL prioritise inputs in RUN as halt > pc_sel > hazard_stall.
REQ-020 RUN, halt=1: pc_write=0, stall_ifid=1, flush_idex=1; next state HALT.
REQ-021 RUN, pc_sel=1, halt=0: in the same cycle pc_write=1, pc_redirect=1, redirect_pc=br_pc[PC_W-1:0], flush_ifid=1, flush_idex=1, with hazard_stall ignored; target registered; next state FLUSH.
REQ-022 RUN, hazard_stall=1 only: pc_write=0, stall_ifid=1, flush_idex=1; stay RUN.
REQ-023 RUN, no request: pc_write=1, all other control outputs 0.
REQ-024 FLUSH lasts exactly one cycle: pc_sel, halt and hazard_stall ignored (wrong-path bubble); pc_write=1, pc_redirect=0, flushes 0; redirect_pc holds registered target; next state RUN.
REQ-025 HALT: pc_write=0, stall_ifid=1, flush_idex=1, halted=1; all inputs except resume ignored; resume=1 gives next state RUN.
REQ-026 halted SHALL be registered: 1 from the first cycle after entering HALT until the cycle after resume.
REQ-027 br_pc bits above PC_W-1 SHALL be discarded without error.
REQ-028 Back-to-back pc_sel on consecutive cycles SHALL produce exactly one redirect.

Reset
REQ-029 With reset=1 at a clock edge, state SHALL become RUN from any state, including mid-FLUSH or HALT.
REQ-030 The same edge SHALL clear the registered target and both counters to 0.
REQ-031 While reset=1, outputs SHALL be: pc_write=0, pc_redirect=0, stall_ifid=0, flush_ifid=1, flush_idex=1, halted=0.

Configuration
REQ-032 Macro BRANCH_STATS_EN defined: taken_cnt SHALL +1 per accepted redirect (REQ-021).
REQ-033 With BRANCH_STATS_EN: stall_cnt SHALL +1 per RUN hazard-stall cycle (REQ-022).
REQ-034 With BRANCH_STATS_EN: both counters SHALL saturate at all-ones.
REQ-035 Macro undefined: both counter ports SHALL stay present, driven constant 0, with no counter logic.

Verification
REQ-036 Reset, then pc_sel=1, br_pc=0x0000_0140 -> same cycle pc_redirect=1, redirect_pc=0x140, both flushes 1; next cycle FLUSH, pc_redirect=0.
REQ-037 pc_sel=1 two consecutive cycles, targets 0x40 then 0x80 -> one redirect to 0x40; taken_cnt=1 with BRANCH_STATS_EN.
REQ-038 hazard_stall=1 three cycles -> pc_write=0, stall_ifid=1, flush_idex=1 each cycle; stall_cnt=3 with BRANCH_STATS_EN.
REQ-039 halt=1 with pc_sel=1, hold 5 cycles, then resume=1 -> HALT entered; halted=1 until cycle after resume; pc_write=0 throughout.
REQ-040 reset=1 during FLUSH and during HALT -> next cycle RUN, halted=0, counters 0.
REQ-041 With BRANCH_STATS_EN, CNT_W=4, 20 redirects -> taken_cnt saturates at 0xF; without the macro -> taken_cnt and stall_cnt stay 0.
